// File: rtl/fp_math_pkg.sv
// Shared types and elaboration helpers for the fixed-point math primitives.
package fp_math_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } fp_sqrt_state_e;

    function automatic int sqrt_iters(input int width, input int frac);
        return (width + frac) / 2;
    endfunction

    // Radicand must split into whole bit pairs and the pair count into whole cycles.
    function automatic bit sqrt_cfg_ok(
        input int width,
        input int int_w,
        input int frac,
        input int steps
    );
        int iters;
        iters = (width + frac) / 2;
        return ((width + frac) % 2 == 0) && (frac >= 0) && (frac < width)
            && (int_w + frac == width) && (steps > 0) && (iters % steps == 0);
    endfunction

endpackage

// File: rtl/fp_sqrt_multi_if.sv
// go/done request bundle between a client and fp_sqrt_multi.
interface fp_sqrt_multi_if #(
    parameter int WIDTH = 32,
    parameter int ITERS = 24
);
    import fp_math_pkg::*;

    logic             go;
    logic             round_en;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [ITERS:0]   rem;
    logic             busy;
    logic             done;

    modport master (
        output go, round_en, in,
        input  out, rem, busy, done
    );

    modport slave (
        input  go, round_en, in,
        output out, rem, busy, done
    );

endinterface

// File: rtl/fp_sqrt_step.sv
// One restoring square-root digit: bring down two radicand bits, trial-subtract.
module fp_sqrt_step
    import fp_math_pkg::*;
#(
    parameter int ITERS = 24
) (
    input  logic [ITERS:0]   acc_i,
    input  logic [ITERS-1:0] q_i,
    input  logic [1:0]       bits_i,
    output logic [ITERS:0]   acc_o,
    output logic [ITERS-1:0] q_o
);
    localparam int AW = ITERS + 1;

    logic [AW+1:0] sh;
    logic [AW+2:0] tmp;
    logic          neg;

    // Remainder never exceeds 2q, so the narrowed result always fits AW bits.
    always_comb begin
        sh    = {acc_i, bits_i};
        tmp   = {1'b0, sh} - {2'b00, q_i, 2'b01};
        neg   = tmp[AW+2];
        acc_o = AW'(neg ? {1'b0, sh} : tmp);
        q_o   = ITERS'({q_i, ~neg});
    end

endmodule

// File: rtl/fp_sqrt_multi.sv
// Multi-digit-per-cycle restoring fixed-point square root with go/done control.
module fp_sqrt_multi
    import fp_math_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int STEPS      = 1
) (
    input logic           clk,
    input logic           reset_n,
    fp_sqrt_multi_if.slave bus
);
    localparam int ITERS  = sqrt_iters(WIDTH, FRAC_WIDTH);
    localparam int CYCLES = ITERS / STEPS;
    localparam int XW     = 2 * ITERS;
    localparam int AW     = ITERS + 1;
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    if (!sqrt_cfg_ok(WIDTH, INT_WIDTH, FRAC_WIDTH, STEPS)) begin : g_cfg_err
        $error("fp_sqrt_multi: inconsistent WIDTH/INT_WIDTH/FRAC_WIDTH/STEPS");
    end

    fp_sqrt_state_e   state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [XW-1:0]    x_q, x_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [ITERS-1:0] q_q, q_d;
    logic             rnd_q, rnd_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [AW-1:0]    rem_q, rem_d;

    logic [AW-1:0]    acc_fin;
    logic [ITERS-1:0] q_fin;
    logic             last;
    logic             round_up;

    for (genvar j = 0; j < STEPS; j++) begin : g_step
        logic [AW-1:0]    acc_in, acc_out;
        logic [ITERS-1:0] q_in, q_out;

        if (j == 0) begin : g_first
            assign acc_in = acc_q;
            assign q_in   = q_q;
        end else begin : g_next
            assign acc_in = g_step[j-1].acc_out;
            assign q_in   = g_step[j-1].q_out;
        end

        fp_sqrt_step #(
            .ITERS (ITERS)
        ) u_step (
            .acc_i  (acc_in),
            .q_i    (q_in),
            .bits_i (x_q[XW-1-2*j -: 2]),
            .acc_o  (acc_out),
            .q_o    (q_out)
        );
    end

    assign acc_fin  = g_step[STEPS-1].acc_out;
    assign q_fin    = g_step[STEPS-1].q_out;
    assign last     = (cnt_q == CW'(CYCLES - 1));
    // Integer remainder: rem > q is exactly rem >= q + 0.25.
    assign round_up = rnd_q && (acc_fin > AW'(q_fin));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        acc_d   = acc_q;
        q_d     = q_q;
        rnd_d   = rnd_q;
        out_d   = out_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    x_d     = XW'(bus.in) << FRAC_WIDTH;
                    acc_d   = '0;
                    q_d     = '0;
                    rnd_d   = bus.round_en;
                end
            end
            RUN: begin
                acc_d = acc_fin;
                q_d   = q_fin;
                x_d   = x_q << (2 * STEPS);
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = FINISH;
                    out_d   = WIDTH'(q_fin) + WIDTH'(round_up);
                    rem_d   = acc_fin;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            rnd_q   <= 1'b0;
            out_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            rnd_q   <= rnd_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == FINISH);
    assign bus.out  = out_q;
    assign bus.rem  = rem_q;

endmodule

// File: tb/tb_fp_sqrt_multi.sv
// Randomised and directed checks of fp_sqrt_multi against an exact integer sqrt model.
module tb_fp_sqrt_multi;
    import fp_math_pkg::*;

    localparam int WIDTH      = 32;
    localparam int INT_WIDTH  = 16;
    localparam int FRAC_WIDTH = 16;
    localparam int STEPS      = 1;
    localparam int ITERS      = (WIDTH + FRAC_WIDTH) / 2;
    localparam int C          = ITERS / STEPS;
    localparam int RW         = ITERS + 1;

    typedef struct {
        logic [WIDTH-1:0] out;
        logic [RW-1:0]    rem;
        longint           t;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n;
    longint cyc = 0;
    int     n_pass = 0;
    int     n_chk = 0;

    exp_t             exq[$];
    logic [WIDTH-1:0] hold_out = '0;
    logic [RW-1:0]    hold_rem = '0;
    longint           run_s = 0;
    longint           run_e = 0;

    fp_sqrt_multi_if #(.WIDTH(WIDTH), .ITERS(ITERS)) bus ();

    fp_sqrt_multi #(
        .WIDTH      (WIDTH),
        .INT_WIDTH  (INT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .STEPS      (STEPS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic longint unsigned isqrt(input longint unsigned r);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 64'd1 << ITERS;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= r) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    task automatic model(input logic [WIDTH-1:0] x, input logic rnd,
                         output logic [WIDTH-1:0] o, output logic [RW-1:0] rm);
        longint unsigned r, q, d;
        r  = 64'(x) << FRAC_WIDTH;
        q  = isqrt(r);
        d  = r - q * q;
        o  = WIDTH'(q + ((rnd && d > q) ? 1 : 0));
        rm = RW'(d);
    endtask

    always @(negedge clk) begin : cmp
        bit exp_done;
        while (exq.size() > 0 && exq[0].t < cyc) begin
            n_chk++;
            $display("FAIL done_missing: got no done, expected done at cycle %0d", exq[0].t);
            void'(exq.pop_front());
        end
        exp_done = (exq.size() > 0) && (exq[0].t == cyc);
        chk("done", 64'(bus.done), 64'(exp_done));
        if (exp_done) begin
            hold_out = exq[0].out;
            hold_rem = exq[0].rem;
            void'(exq.pop_front());
        end
        chk("out", 64'(bus.out), 64'(hold_out));
        chk("rem", 64'(bus.rem), 64'(hold_rem));
        chk("busy", 64'(bus.busy), 64'(cyc >= run_s && cyc < run_e));
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_chk++;
            $display("FAIL idle_wait: got busy=%0b expected 0 within 500 cycles", bus.busy);
        end
    endtask

    task automatic accept(input logic [WIDTH-1:0] x, input logic rnd);
        exp_t e;
        model(x, rnd, e.out, e.rem);
        e.t   = cyc + C;
        run_s = cyc;
        run_e = cyc + C;
        exq.push_back(e);
    endtask

    task automatic start_op(input logic [WIDTH-1:0] x, input logic rnd);
        wait_idle();
        #1;
        bus.go       = 1'b1;
        bus.in       = x;
        bus.round_en = rnd;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        bus.in = $urandom;
        accept(x, rnd);
    endtask

    task automatic drain();
        int n = 0;
        while (exq.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_chk++;
            $display("FAIL drain: got %0d pending results expected 0", exq.size());
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : drv
        logic [WIDTH-1:0] o;
        logic [RW-1:0]    rm;
        logic [WIDTH-1:0] vals[3];

        reset_n      = 1'b0;
        bus.go       = 1'b0;
        bus.round_en = 1'b0;
        bus.in       = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out", 64'(bus.out), 64'd0);
        chk("rst_rem", 64'(bus.rem), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        #1 reset_n = 1'b1;

        model(32'h0004_0000, 1'b0, o, rm);
        chk("model_4_out", 64'(o), 64'h0002_0000);
        chk("model_4_rem", 64'(rm), 64'd0);
        model(32'h0002_0000, 1'b0, o, rm);
        chk("model_2t_out", 64'(o), 64'h0001_6A09);
        chk("model_2t_rem", 64'(rm), 64'd166831);
        model(32'h0002_0000, 1'b1, o, rm);
        chk("model_2r_out", 64'(o), 64'h0001_6A0A);
        chk("model_2r_rem", 64'(rm), 64'd166831);
        model(32'hFFFF_FFFF, 1'b0, o, rm);
        chk("model_maxt_out", 64'(o), 64'h00FF_FFFF);
        model(32'hFFFF_FFFF, 1'b1, o, rm);
        chk("model_maxr_out", 64'(o), 64'h0100_0000);
        chk("model_maxr_rem", 64'(rm), 64'd33488895);

        start_op(32'h0004_0000, 1'b0);
        start_op(32'h0002_0000, 1'b0);
        start_op(32'h0002_0000, 1'b1);
        start_op(32'h0000_0000, 1'b0);
        start_op(32'h0000_0000, 1'b1);
        start_op(32'hFFFF_FFFF, 1'b0);
        start_op(32'hFFFF_FFFF, 1'b1);
        drain();

        // go pulsed mid-run with a different radicand must be ignored
        start_op(32'h0009_0000, 1'b0);
        @(negedge clk);
        #1;
        bus.go = 1'b1;
        bus.in = 32'h0019_0000;
        @(negedge clk);
        #1;
        bus.go = 1'b0;
        drain();

        // reset mid-run
        start_op(32'h1234_5678, 1'b1);
        repeat (C / 2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        exq.delete();
        run_e    = 0;
        hold_out = '0;
        hold_rem = '0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_out", 64'(bus.out), 64'd0);
        chk("midrst_rem", 64'(bus.rem), 64'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (C + 3) @(negedge clk);
        start_op(32'h0002_0000, 1'b1);
        drain();

        // go held high: three back-to-back operations
        vals[0] = 32'h0010_0000;
        vals[1] = 32'h0003_0000;
        vals[2] = $urandom;
        wait_idle();
        #1;
        bus.go       = 1'b1;
        bus.in       = vals[0];
        bus.round_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            accept(vals[k], 1'b1);
            if (k < 2) begin
                bus.in = vals[k+1];
                repeat (C + 1) @(posedge clk);
            end else begin
                bus.go = 1'b0;
            end
        end
        drain();

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] x;
            x = $urandom;
            if ($urandom_range(0, 3) == 0) x = WIDTH'($urandom_range(0, 65535));
            start_op(x, 1'($urandom_range(0, 1)));
        end
        drain();

        chk("queue_drained", 64'(exq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
